// File: rtl/b2_serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell and a carry flop, LSB first.
// Operands arrive on a start/ready handshake; results leave on a valid/ack handshake.
module b2_serial_adder #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ack
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  r_reg;
  logic [N-1:0]  r_next;
  logic          carry;
  logic [CW-1:0] bit_cnt;
  logic          sum_bit;
  logic          carry_next;
  logic          last_bit;

  always_comb begin
    sum_bit    = a_reg[0] ^ b_reg[0] ^ carry;
    carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    r_next     = {sum_bit, r_reg[N-1:1]};
    last_bit   = (bit_cnt == CW'(N - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      carry     <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= x;
            // Subtraction is x + ~y + 1, so invert y and force the carry-in.
            b_reg   <= sub ? ~y : y;
            carry   <= sub | cin;
            bit_cnt <= '0;
            ready   <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          carry <= carry_next;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          r_reg <= r_next;
          if (last_bit) begin
            // carry here is still the carry into the MSB.
            s         <= r_next;
            cout      <= carry_next;
            ovf       <= carry ^ carry_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            ready     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          ready     <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b2_serial_adder.sv
// Directed and randomized checks of b2_serial_adder against an integer-arithmetic model.
module tb_b2_serial_adder;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         ready;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;
  logic         out_valid;
  logic         out_ack = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  b2_serial_adder #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .ready(ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .s(s), .cout(cout), .ovf(ovf), .out_valid(out_valid), .out_ack(out_ack)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic in unsigned and signed views.
  function automatic logic [N+1:0] model(input logic [N-1:0] xa, input logic [N-1:0] ya,
                                         input logic ci, input logic sb);
    int ux, uy, sx, sy, u, sr;
    logic c, v;
    ux = int'(xa);
    uy = int'(ya);
    sx = xa[N-1] ? ux - (1 << N) : ux;
    sy = ya[N-1] ? uy - (1 << N) : uy;
    if (sb) begin
      u  = ux - uy;
      sr = sx - sy;
      c  = (ux >= uy);
    end else begin
      u  = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      c  = (u >= (1 << N));
    end
    v = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
    return {v, c, N'(u & ((1 << N) - 1))};
  endfunction

  // Accept an operation, scramble inputs during RUN, check latency, hold-over and result.
  task automatic run_op(input string tag, input logic [N-1:0] xa, input logic [N-1:0] ya,
                        input logic ci, input logic sb, input logic do_ack);
    logic [N+1:0] exp;
    logic [N-1:0] prev_s;
    int k;
    exp    = model(xa, ya, ci, sb);
    prev_s = s;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    x = xa; y = ya; cin = ci; sub = sb; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      x = N'($urandom); y = N'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (k == 3) chk({tag, "_hold_s"}, 32'(s), 32'(prev_s));
      step();
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(N));
    chk({tag, "_s"},    32'(s),    32'(exp[N-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(exp[N]));
    chk({tag, "_ovf"},  32'(ovf),  32'(exp[N+1]));
    if (do_ack) begin
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      chk({tag, "_ack_ready"}, 32'(ready), 32'd1);
      chk({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [N+1:0] held;
    logic [N-1:0] rx, ry;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_s",     32'(s), 32'd0);
    chk("rst_cout",  32'(cout), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    reset = 1'b0;
    step();

    run_op("add",     8'h35, 8'h4A, 1'b0, 1'b0, 1'b1);
    chk("add_lit", 32'(s), 32'h7F);
    run_op("carry",   8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("carry_lit", 32'({cout, s}), 32'h100);
    run_op("cin",     8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("cin_lit", 32'({cout, s}), 32'h100);
    run_op("sovf",    8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("sovf_lit", 32'({ovf, cout, s}), 32'h280);
    run_op("subovf",  8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    chk("subovf_lit", 32'({ovf, cout, s}), 32'h37F);
    run_op("borrow",  8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
    chk("borrow_lit", 32'({ovf, cout, s}), 32'h0FE);

    // Back-pressure: result must hold while start/x/y toggle and ack is low.
    run_op("bp", 8'hC3, 8'h5A, 1'b1, 1'b0, 1'b0);
    held = {ovf, cout, s};
    for (int i = 0; i < 5; i++) begin
      start = ~start; x = N'($urandom); y = N'($urandom);
      step();
      chk("bp_hold", 32'({ovf, cout, s}), 32'(held));
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ack = 1'b1; start = 1'b1;
    step();
    out_ack = 1'b0; start = 1'b0;
    chk("bp_ready", 32'(ready), 32'd1);
    chk("bp_valid_low", 32'(out_valid), 32'd0);
    step();
    chk("bp_no_new_op", 32'(ready), 32'd1);
    chk("bp_keep", 32'({ovf, cout, s}), 32'(held));

    // Reset on the third RUN cycle.
    x = 8'hAA; y = 8'h77; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_res",   32'({ovf, cout, s}), 32'd0);
    run_op("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    chk("post_rst_lit", 32'({ovf, cout, s}), 32'h030);

    for (int i = 0; i < 40; i++) begin
      rx = N'($urandom);
      ry = N'($urandom);
      run_op("rand", rx, ry, 1'($urandom), 1'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
